// File: rtl/dispatcher.sv
// Dispatch stage: resolves source operands, allocates a ROB alias and issues one registered packet to RS or LSB.
// Optional DISP_PERF_CNT_EN adds perf_disp_cnt / perf_stall_cnt counters.
module dispatcher #(
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32,
   parameter int OPT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback_from_rob,
   input  logic              valid_from_dec,
   input  logic              to_lsb_from_dec,
   input  logic [OPT_W-1:0]  inst_type_from_dec,
   input  logic [DATA_W-1:0] pc_from_dec,
   input  logic [DATA_W-1:0] imm_from_dec,
   input  logic [4:0]        rd_from_dec,
   input  logic [4:0]        rs1_from_dec,
   input  logic [4:0]        rs2_from_dec,
   output logic              stall_to_dec,
   input  logic              rob_full,
   input  logic [ROB_W-1:0]  rob_tail_alias,
   input  logic              rs_full,
   input  logic              lsb_full,
   output logic [4:0]        rs1_to_rf,
   output logic [4:0]        rs2_to_rf,
   input  logic [ROB_W-1:0]  Q1_from_rf,
   input  logic [ROB_W-1:0]  Q2_from_rf,
   input  logic [DATA_W-1:0] V1_from_rf,
   input  logic [DATA_W-1:0] V2_from_rf,
   output logic [ROB_W-1:0]  query1_to_rob,
   output logic [ROB_W-1:0]  query2_to_rob,
   input  logic              ready1_from_rob,
   input  logic              ready2_from_rob,
   input  logic [DATA_W-1:0] value1_from_rob,
   input  logic [DATA_W-1:0] value2_from_rob,
   input  logic              valid_from_alu,
   input  logic [ROB_W-1:0]  alias_from_alu,
   input  logic [DATA_W-1:0] result_from_alu,
   input  logic              valid_from_lsb,
   input  logic [ROB_W-1:0]  alias_from_lsb,
   input  logic [DATA_W-1:0] result_from_lsb,
   output logic              valid_to_rs,
   output logic              valid_to_lsb,
   output logic [DATA_W-1:0] pc_to_exec,
   output logic [DATA_W-1:0] imm_to_exec,
   output logic [DATA_W-1:0] Vi_to_exec,
   output logic [DATA_W-1:0] Vj_to_exec,
   output logic [OPT_W-1:0]  inst_type_to_exec,
   output logic [ROB_W-1:0]  rd_to_exec,
   output logic [ROB_W-1:0]  Qi_to_exec,
   output logic [ROB_W-1:0]  Qj_to_exec,
   output logic              valid_to_rob,
   output logic [4:0]        rd_to_rob,
   output logic              rename_valid_to_rf,
   output logic [ROB_W-1:0]  rename_alias_to_rf
`ifdef DISP_PERF_CNT_EN
   ,
   output logic [31:0]       perf_disp_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   logic              validRs_q, validLsb_q, validRob_q, renameValid_q;
   logic [DATA_W-1:0] pc_q, imm_q, vi_q, vj_q, vi_d, vj_d;
   logic [OPT_W-1:0]  instType_q;
   logic [ROB_W-1:0]  rdAlias_q, qi_q, qj_q, qi_d, qj_d;
   logic [4:0]        rdArch_q;
   logic              bypValid_q;
   logic [4:0]        bypRd_q;
   logic [ROB_W-1:0]  bypAlias_q;
   logic              accept, bypHit1, bypHit2;

   // A pulse still sitting on the output occupies the only free slot we may assume.
   assign stall_to_dec = rob_full | (to_lsb_from_dec ? (lsb_full | validLsb_q)
                                                      : (rs_full | validRs_q));
   assign accept = valid_from_dec & ~stall_to_dec & rdy & ~rollback_from_rob;

   assign rs1_to_rf     = rs1_from_dec;
   assign rs2_to_rf     = rs2_from_dec;
   assign query1_to_rob = Q1_from_rf;
   assign query2_to_rob = Q2_from_rf;

   assign bypHit1 = bypValid_q && (bypRd_q != 5'd0) && (bypRd_q == rs1_from_dec);
   assign bypHit2 = bypValid_q && (bypRd_q != 5'd0) && (bypRd_q == rs2_from_dec);

   function automatic logic [ROB_W+DATA_W-1:0] resolveOperand(
      input logic [4:0]        rs,
      input logic [ROB_W-1:0]  qRf,
      input logic [DATA_W-1:0] vRf,
      input logic              robReady,
      input logic [DATA_W-1:0] robValue,
      input logic              bypHit,
      input logic [ROB_W-1:0]  bypAlias,
      input logic              aluValid,
      input logic [ROB_W-1:0]  aluAlias,
      input logic [DATA_W-1:0] aluResult,
      input logic              lsbValid,
      input logic [ROB_W-1:0]  lsbAlias,
      input logic [DATA_W-1:0] lsbResult);
      logic [ROB_W-1:0] tag;
      if (rs == 5'd0) return '0;
      if (bypHit) tag = bypAlias;
      else if (qRf == '0) return {{ROB_W{1'b0}}, vRf};
      else tag = qRf;
      if (lsbValid && lsbAlias == tag) return {{ROB_W{1'b0}}, lsbResult};
      if (aluValid && aluAlias == tag) return {{ROB_W{1'b0}}, aluResult};
      // The ROB was queried with the register-file tag, which is stale on a bypass hit.
      if (!bypHit && robReady) return {{ROB_W{1'b0}}, robValue};
      return {tag, {DATA_W{1'b0}}};
   endfunction

   always_comb begin
      {qi_d, vi_d} = resolveOperand(rs1_from_dec, Q1_from_rf, V1_from_rf, ready1_from_rob,
                                    value1_from_rob, bypHit1, bypAlias_q,
                                    valid_from_alu, alias_from_alu, result_from_alu,
                                    valid_from_lsb, alias_from_lsb, result_from_lsb);
      {qj_d, vj_d} = resolveOperand(rs2_from_dec, Q2_from_rf, V2_from_rf, ready2_from_rob,
                                    value2_from_rob, bypHit2, bypAlias_q,
                                    valid_from_alu, alias_from_alu, result_from_alu,
                                    valid_from_lsb, alias_from_lsb, result_from_lsb);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validRs_q     <= 1'b0;
         validLsb_q    <= 1'b0;
         validRob_q    <= 1'b0;
         renameValid_q <= 1'b0;
         pc_q          <= '0;
         imm_q         <= '0;
         vi_q          <= '0;
         vj_q          <= '0;
         instType_q    <= '0;
         rdAlias_q     <= '0;
         qi_q          <= '0;
         qj_q          <= '0;
         rdArch_q      <= '0;
         bypValid_q    <= 1'b0;
         bypRd_q       <= '0;
         bypAlias_q    <= '0;
      end else if (rdy) begin
         validRs_q     <= accept & ~to_lsb_from_dec;
         validLsb_q    <= accept & to_lsb_from_dec;
         validRob_q    <= accept;
         renameValid_q <= accept & (rd_from_dec != 5'd0);
         bypValid_q    <= accept;
         if (accept) begin
            pc_q       <= pc_from_dec;
            imm_q      <= imm_from_dec;
            vi_q       <= vi_d;
            vj_q       <= vj_d;
            qi_q       <= qi_d;
            qj_q       <= qj_d;
            instType_q <= inst_type_from_dec;
            rdAlias_q  <= rob_tail_alias;
            rdArch_q   <= rd_from_dec;
            bypRd_q    <= rd_from_dec;
            bypAlias_q <= rob_tail_alias;
         end
      end
   end

   assign valid_to_rs        = validRs_q;
   assign valid_to_lsb       = validLsb_q;
   assign valid_to_rob       = validRob_q;
   assign rename_valid_to_rf = renameValid_q;
   assign pc_to_exec         = pc_q;
   assign imm_to_exec        = imm_q;
   assign Vi_to_exec         = vi_q;
   assign Vj_to_exec         = vj_q;
   assign Qi_to_exec         = qi_q;
   assign Qj_to_exec         = qj_q;
   assign inst_type_to_exec  = instType_q;
   assign rd_to_exec         = rdAlias_q;
   assign rename_alias_to_rf = rdAlias_q;
   assign rd_to_rob          = rdArch_q;

`ifdef DISP_PERF_CNT_EN
   logic [31:0] perfDisp_q, perfStall_q;

   // Counters survive rollback so they reflect total activity since reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perfDisp_q  <= '0;
         perfStall_q <= '0;
      end else begin
         if (accept) perfDisp_q <= perfDisp_q + 32'd1;
         if (valid_from_dec & stall_to_dec & rdy) perfStall_q <= perfStall_q + 32'd1;
      end
   end

   assign perf_disp_cnt  = perfDisp_q;
   assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_dispatcher.sv
// Directed self-checking bench for the dispatcher: operand resolution, bypass, stalls, rollback, rdy hold, reset.
module tb_dispatcher;

   logic        clk, rst, rdy, rollback_from_rob;
   logic        valid_from_dec, to_lsb_from_dec;
   logic [5:0]  inst_type_from_dec;
   logic [31:0] pc_from_dec, imm_from_dec;
   logic [4:0]  rd_from_dec, rs1_from_dec, rs2_from_dec;
   logic        stall_to_dec, rob_full, rs_full, lsb_full;
   logic [3:0]  rob_tail_alias;
   logic [4:0]  rs1_to_rf, rs2_to_rf;
   logic [3:0]  Q1_from_rf, Q2_from_rf, query1_to_rob, query2_to_rob;
   logic [31:0] V1_from_rf, V2_from_rf, value1_from_rob, value2_from_rob;
   logic        ready1_from_rob, ready2_from_rob;
   logic        valid_from_alu, valid_from_lsb;
   logic [3:0]  alias_from_alu, alias_from_lsb;
   logic [31:0] result_from_alu, result_from_lsb;
   logic        valid_to_rs, valid_to_lsb, valid_to_rob, rename_valid_to_rf;
   logic [31:0] pc_to_exec, imm_to_exec, Vi_to_exec, Vj_to_exec;
   logic [5:0]  inst_type_to_exec;
   logic [3:0]  rd_to_exec, Qi_to_exec, Qj_to_exec, rename_alias_to_rf;
   logic [4:0]  rd_to_rob;
`ifdef DISP_PERF_CNT_EN
   logic [31:0] perf_disp_cnt, perf_stall_cnt;
`endif

   int assertCount = 0;
   int failCount   = 0;

   dispatcher dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback_from_rob(rollback_from_rob),
      .valid_from_dec(valid_from_dec), .to_lsb_from_dec(to_lsb_from_dec),
      .inst_type_from_dec(inst_type_from_dec), .pc_from_dec(pc_from_dec),
      .imm_from_dec(imm_from_dec), .rd_from_dec(rd_from_dec),
      .rs1_from_dec(rs1_from_dec), .rs2_from_dec(rs2_from_dec),
      .stall_to_dec(stall_to_dec), .rob_full(rob_full), .rob_tail_alias(rob_tail_alias),
      .rs_full(rs_full), .lsb_full(lsb_full),
      .rs1_to_rf(rs1_to_rf), .rs2_to_rf(rs2_to_rf),
      .Q1_from_rf(Q1_from_rf), .Q2_from_rf(Q2_from_rf),
      .V1_from_rf(V1_from_rf), .V2_from_rf(V2_from_rf),
      .query1_to_rob(query1_to_rob), .query2_to_rob(query2_to_rob),
      .ready1_from_rob(ready1_from_rob), .ready2_from_rob(ready2_from_rob),
      .value1_from_rob(value1_from_rob), .value2_from_rob(value2_from_rob),
      .valid_from_alu(valid_from_alu), .alias_from_alu(alias_from_alu),
      .result_from_alu(result_from_alu),
      .valid_from_lsb(valid_from_lsb), .alias_from_lsb(alias_from_lsb),
      .result_from_lsb(result_from_lsb),
      .valid_to_rs(valid_to_rs), .valid_to_lsb(valid_to_lsb),
      .pc_to_exec(pc_to_exec), .imm_to_exec(imm_to_exec),
      .Vi_to_exec(Vi_to_exec), .Vj_to_exec(Vj_to_exec),
      .inst_type_to_exec(inst_type_to_exec), .rd_to_exec(rd_to_exec),
      .Qi_to_exec(Qi_to_exec), .Qj_to_exec(Qj_to_exec),
      .valid_to_rob(valid_to_rob), .rd_to_rob(rd_to_rob),
      .rename_valid_to_rf(rename_valid_to_rf), .rename_alias_to_rf(rename_alias_to_rf)
`ifdef DISP_PERF_CNT_EN
      ,
      .perf_disp_cnt(perf_disp_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic toLsb, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [3:0] tail);
      valid_from_dec     = 1'b1;
      to_lsb_from_dec    = toLsb;
      inst_type_from_dec = toLsb ? 6'h03 : 6'h13;
      pc_from_dec        = pc_from_dec + 32'd4;
      imm_from_dec       = {27'd0, rd};
      rd_from_dec        = rd;
      rs1_from_dec       = rs1;
      rs2_from_dec       = rs2;
      rob_tail_alias     = tail;
   endtask

   task automatic clearSide();
      valid_from_dec  = 1'b0;
      Q1_from_rf = '0; Q2_from_rf = '0; V1_from_rf = '0; V2_from_rf = '0;
      ready1_from_rob = 1'b0; ready2_from_rob = 1'b0;
      value1_from_rob = '0; value2_from_rob = '0;
      valid_from_alu = 1'b0; alias_from_alu = '0; result_from_alu = '0;
      valid_from_lsb = 1'b0; alias_from_lsb = '0; result_from_lsb = '0;
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; rollback_from_rob = 1'b0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      to_lsb_from_dec = 1'b0; inst_type_from_dec = '0; pc_from_dec = 32'h100;
      imm_from_dec = '0; rd_from_dec = '0; rs1_from_dec = '0; rs2_from_dec = '0;
      rob_tail_alias = 4'd1;
      clearSide();

      // Reset state
      @(negedge clk);
      checkOutput("rst_valid_rs", valid_to_rs, 0);
      checkOutput("rst_valid_rob", valid_to_rob, 0);
      checkOutput("rst_rd_exec", rd_to_exec, 0);
      checkOutput("rst_rename", rename_valid_to_rf, 0);
      rst = 1'b1;

      // addi x5,x0,7 at alias 3
      applyStimulus(1'b0, 5'd5, 5'd0, 5'd0, 4'd3);
      imm_from_dec = 32'd7;
      V1_from_rf = 32'hAAAA;
      #1 checkOutput("addi_stall", stall_to_dec, 0);
      checkOutput("rs1_to_rf", rs1_to_rf, 0);

      @(negedge clk);
      checkOutput("addi_valid_rs", valid_to_rs, 1);
      checkOutput("addi_valid_lsb", valid_to_lsb, 0);
      checkOutput("addi_valid_rob", valid_to_rob, 1);
      checkOutput("addi_rd_rob", rd_to_rob, 5);
      checkOutput("addi_rename", rename_valid_to_rf, 1);
      checkOutput("addi_rename_alias", rename_alias_to_rf, 3);
      checkOutput("addi_rd_exec", rd_to_exec, 3);
      checkOutput("addi_Qi", Qi_to_exec, 0);
      checkOutput("addi_Vi", Vi_to_exec, 0);
      checkOutput("addi_imm", imm_to_exec, 7);
      checkOutput("addi_type", inst_type_to_exec, 6'h13);
      // add x6,x5,x5 stalls behind the pending RS pulse
      applyStimulus(1'b0, 5'd6, 5'd5, 5'd5, 4'd4);
      V1_from_rf = 32'h55;
      #1 checkOutput("add_stall", stall_to_dec, 1);

      @(negedge clk);
      checkOutput("add_gap_valid_rs", valid_to_rs, 0);
      checkOutput("add_gap_valid_rob", valid_to_rob, 0);
      checkOutput("add_gap_rd_hold", rd_to_exec, 3);
      Q1_from_rf = 4'd3; Q2_from_rf = 4'd3; V1_from_rf = '0;
      #1 checkOutput("add_stall_free", stall_to_dec, 0);
      checkOutput("query1", query1_to_rob, 3);

      @(negedge clk);
      checkOutput("add_valid_rs", valid_to_rs, 1);
      checkOutput("add_Qi", Qi_to_exec, 3);
      checkOutput("add_Qj", Qj_to_exec, 3);
      checkOutput("add_Vi", Vi_to_exec, 0);
      checkOutput("add_Vj", Vj_to_exec, 0);
      checkOutput("add_rd_exec", rd_to_exec, 4);
      checkOutput("add_rename_alias", rename_alias_to_rf, 4);
      checkOutput("add_rd_rob", rd_to_rob, 6);
      // load x7 from x2 (register-file value ready)
      clearSide();
      applyStimulus(1'b1, 5'd7, 5'd2, 5'd0, 4'd5);
      V1_from_rf = 32'h1000;
      #1 checkOutput("ld_stall", stall_to_dec, 0);

      @(negedge clk);
      checkOutput("ld_valid_lsb", valid_to_lsb, 1);
      checkOutput("ld_valid_rs", valid_to_rs, 0);
      checkOutput("ld_Vi", Vi_to_exec, 32'h1000);
      checkOutput("ld_rd_exec", rd_to_exec, 5);
      // back-to-back consumer of x7 sees stale RF
      clearSide();
      applyStimulus(1'b0, 5'd8, 5'd7, 5'd0, 4'd6);
      V1_from_rf = 32'h99;

      @(negedge clk);
      checkOutput("byp_valid_rs", valid_to_rs, 1);
      checkOutput("byp_Qi", Qi_to_exec, 5);
      checkOutput("byp_Vi", Vi_to_exec, 0);
      checkOutput("byp_Qj", Qj_to_exec, 0);
      // store reading x8 while ALU broadcasts alias 6
      clearSide();
      applyStimulus(1'b1, 5'd0, 5'd8, 5'd0, 4'd7);
      V1_from_rf = 32'h77;
      valid_from_alu = 1'b1; alias_from_alu = 4'd6; result_from_alu = 32'hBEEF;

      @(negedge clk);
      checkOutput("bypcdb_valid_lsb", valid_to_lsb, 1);
      checkOutput("bypcdb_Qi", Qi_to_exec, 0);
      checkOutput("bypcdb_Vi", Vi_to_exec, 32'hBEEF);
      checkOutput("bypcdb_rename_rd0", rename_valid_to_rf, 0);
      checkOutput("bypcdb_valid_rob", valid_to_rob, 1);
      // ALU CDB forwarding for Q1=2
      clearSide();
      applyStimulus(1'b0, 5'd9, 5'd1, 5'd3, 4'd8);
      Q1_from_rf = 4'd2;
      valid_from_alu = 1'b1; alias_from_alu = 4'd2; result_from_alu = 32'hDEAD;
      V2_from_rf = 32'h22;
      #1 checkOutput("alu_stall", stall_to_dec, 0);

      @(negedge clk);
      checkOutput("alu_Qi", Qi_to_exec, 0);
      checkOutput("alu_Vi", Vi_to_exec, 32'hDEAD);
      checkOutput("alu_Qj", Qj_to_exec, 0);
      checkOutput("alu_Vj", Vj_to_exec, 32'h22);
      checkOutput("alu_rename", rename_valid_to_rf, 1);
      checkOutput("alu_rename_alias", rename_alias_to_rf, 8);
      clearSide();

      @(negedge clk);
      checkOutput("idle_valid_rs", valid_to_rs, 0);
      // ALU and LSB both broadcast alias 2; rs2 = x0 ignores RF tag
      applyStimulus(1'b0, 5'd10, 5'd1, 5'd0, 4'd9);
      Q1_from_rf = 4'd2;
      valid_from_alu = 1'b1; alias_from_alu = 4'd2; result_from_alu = 32'hDEAD;
      valid_from_lsb = 1'b1; alias_from_lsb = 4'd2; result_from_lsb = 32'hCAFE;
      Q2_from_rf = 4'd7; V2_from_rf = 32'h77;

      @(negedge clk);
      checkOutput("lsbwin_Qi", Qi_to_exec, 0);
      checkOutput("lsbwin_Vi", Vi_to_exec, 32'hCAFE);
      checkOutput("x0_Qj", Qj_to_exec, 0);
      checkOutput("x0_Vj", Vj_to_exec, 0);
      clearSide();

      @(negedge clk);
      // ROB lookup: ready for source 1, not ready for source 2
      applyStimulus(1'b0, 5'd11, 5'd1, 5'd2, 4'd10);
      Q1_from_rf = 4'd5; ready1_from_rob = 1'b1; value1_from_rob = 32'h10;
      Q2_from_rf = 4'd5; ready2_from_rob = 1'b0; value2_from_rob = 32'h20;
      #1 checkOutput("rob_stall", stall_to_dec, 0);

      @(negedge clk);
      checkOutput("rob_Qi", Qi_to_exec, 0);
      checkOutput("rob_Vi", Vi_to_exec, 32'h10);
      checkOutput("rob_Qj", Qj_to_exec, 5);
      checkOutput("rob_Vj", Vj_to_exec, 0);
      clearSide();

      @(negedge clk);
      rs_full = 1'b1;
      applyStimulus(1'b0, 5'd12, 5'd0, 5'd0, 4'd11);
      #1 checkOutput("rsfull_stall", stall_to_dec, 1);

      @(negedge clk);
      checkOutput("rsfull_valid_rs", valid_to_rs, 0);
      checkOutput("rsfull_valid_rob", valid_to_rob, 0);
      rs_full = 1'b0; rob_full = 1'b1;
      applyStimulus(1'b1, 5'd12, 5'd0, 5'd0, 4'd11);
      #1 checkOutput("robfull_stall", stall_to_dec, 1);

      @(negedge clk);
      checkOutput("robfull_valid_lsb", valid_to_lsb, 0);
      rob_full = 1'b0; lsb_full = 1'b1;
      #1 checkOutput("lsbfull_stall", stall_to_dec, 1);
      to_lsb_from_dec = 1'b0;
      #1 checkOutput("lsbfull_rs_ok", stall_to_dec, 0);

      @(negedge clk);
      checkOutput("lsbfull_rs_valid", valid_to_rs, 1);
      checkOutput("lsbfull_rs_rd", rd_to_exec, 11);
      lsb_full = 1'b0;
      applyStimulus(1'b1, 5'd13, 5'd0, 5'd0, 4'd12);

      @(negedge clk);
      checkOutput("pre_rb_valid_lsb", valid_to_lsb, 1);
      applyStimulus(1'b0, 5'd14, 5'd0, 5'd0, 4'd13);
      rollback_from_rob = 1'b1;

      @(negedge clk);
      checkOutput("rb_valid_lsb", valid_to_lsb, 0);
      checkOutput("rb_valid_rs", valid_to_rs, 0);
      checkOutput("rb_valid_rob", valid_to_rob, 0);
      checkOutput("rb_rd_hold", rd_to_exec, 12);
      rollback_from_rob = 1'b0;
      applyStimulus(1'b1, 5'd15, 5'd0, 5'd0, 4'd14);

      @(negedge clk);
      checkOutput("hold_pre_lsb", valid_to_lsb, 1);
      rdy = 1'b0;
      applyStimulus(1'b0, 5'd16, 5'd0, 5'd0, 4'd15);
      #1 checkOutput("hold_stall", stall_to_dec, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_valid_lsb", valid_to_lsb, 1);
         checkOutput("hold_valid_rs", valid_to_rs, 0);
         checkOutput("hold_rename", rename_valid_to_rf, 1);
      end
      rdy = 1'b1;
      valid_from_dec = 1'b0;

      @(negedge clk);
      checkOutput("release_valid_lsb", valid_to_lsb, 0);
      applyStimulus(1'b0, 5'd16, 5'd0, 5'd0, 4'd15);

      @(negedge clk);
      checkOutput("prerst_valid_rs", valid_to_rs, 1);
      #2 rst = 1'b0;
      #1 checkOutput("midrst_valid_rs", valid_to_rs, 0);
      checkOutput("midrst_rd_exec", rd_to_exec, 0);
      checkOutput("midrst_valid_rob", valid_to_rob, 0);

      @(negedge clk);
      rst = 1'b1;
      #1 checkOutput("postrst_stall", stall_to_dec, 0);

      @(negedge clk);
      checkOutput("postrst_valid_rs", valid_to_rs, 1);
      checkOutput("postrst_rd_exec", rd_to_exec, 15);
      checkOutput("postrst_rd_rob", rd_to_rob, 16);
      clearSide();

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Transmitting end of the reservation-station and load/store-buffer dispatch interface.
- Takes one decoded instruction per cycle from the instruction queue and allocates a ROB alias for it.
- Resolves both source operands (register file, same-cycle CDB, ROB lookup, back-to-back bypass) into (Q,V) pairs.
- Sends one registered dispatch packet to either RS or LSB, plus ROB-allocate and register-rename pulses.

Parameters:
ROB_W, 4, alias width; alias 0 = "no dependency", valid aliases 1..2^ROB_W-1
DATA_W, 32, operand/imm/pc width
OPT_W, 6, inst_type encoding width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = hold all state
rollback_from_rob  in  1  flush
valid_from_dec/to_lsb_from_dec  in  1/1  instruction present / targets LSB (else RS)
inst_type_from_dec  in  OPT_W  opcode class
pc_from_dec/imm_from_dec  in  DATA_W  pc, immediate
rd_from_dec/rs1_from_dec/rs2_from_dec  in  5  architectural regs
stall_to_dec  out  1  combinational; instruction not accepted this cycle
rob_full  in  1  ROB has fewer than 2 free entries
rob_tail_alias  in  ROB_W  alias for next allocation (never 0)
rs_full/lsb_full  in  1/1  destination full
rs1_to_rf/rs2_to_rf  out  5  combinational copies of rs1/rs2_from_dec
Q1_from_rf/Q2_from_rf  in  ROB_W  rename tag (0 = value valid)
V1_from_rf/V2_from_rf  in  DATA_W  register value
query1_to_rob/query2_to_rob  out  ROB_W  = Q1/Q2_from_rf
ready1_from_rob/ready2_from_rob  in  1  queried entry has result
value1_from_rob/value2_from_rob  in  DATA_W  that result
valid_from_alu/alias_from_alu/result_from_alu  in  1/ROB_W/DATA_W  ALU CDB
valid_from_lsb/alias_from_lsb/result_from_lsb  in  1/ROB_W/DATA_W  LSB CDB
valid_to_rs/valid_to_lsb  out  1/1  one-cycle dispatch pulses
pc_to_exec/imm_to_exec/Vi_to_exec/Vj_to_exec  out  DATA_W  shared packet
inst_type_to_exec  out  OPT_W
rd_to_exec/Qi_to_exec/Qj_to_exec  out  ROB_W  dest alias, source tags
valid_to_rob/rd_to_rob  out  1/5  ROB allocate, arch rd
rename_valid_to_rf/rename_alias_to_rf  out  1/ROB_W  rename rd_to_rob to alias

Behaviour:
- Reset (rst=0, async): every output reg = 0; bypass register cleared.
- stall_to_dec = rob_full | (to_lsb ? lsb_full | valid_to_lsb : rs_full | valid_to_rs).
- Pending pulse counts as one consumed slot, so the same unit cannot receive on consecutive cycles.
- accept = valid_from_dec & !stall_to_dec & rdy & !rollback_from_rob.
- Operand resolution (each source independently), priority high to low:
  - rs==0 -> Q=0, V=0.
  - Bypass hit (last accepted instr had rd==rs, rd!=0, accepted previous cycle) -> Q=last alias, V=0; CDB check still applied against that alias.
  - Q_from_rf==0 -> Q=0, V=V_from_rf.
  - LSB CDB alias match -> Q=0, V=result_from_lsb.
  - ALU CDB alias match -> Q=0, V=result_from_alu.
  - ready_from_rob -> Q=0, V=value_from_rob.
  - Otherwise Q=Q_from_rf, V=0.
- Latency: accept in cycle N -> packet, valid_to_rs|lsb, valid_to_rob pulse high during N+1 only.
- rename_valid_to_rf pulses in N+1 only if rd!=0. rd_to_exec = rob_tail_alias sampled at N.
- No accept -> all valid outputs 0 next cycle; data fields hold.
- rollback_from_rob: clears all valid outputs and bypass next edge; wins over a simultaneous accept (instruction dropped, decoder refetches).
- rdy=0: every register holds, including asserted valid pulses; pulse completes on the first rdy=1 cycle.

Optional Feature:
- DISP_PERF_CNT_EN defined: adds outputs perf_disp_cnt and perf_stall_cnt (32 bit).
  - perf_disp_cnt increments per accept.
  - perf_stall_cnt increments per cycle with valid_from_dec & stall_to_dec & rdy.
  - Both wrap at 2^32, clear on reset only (not rollback).
- Undefined: ports and counters absent.

Test Plan:
- Reset mid-stream: rst=0 while valid_to_rs=1 -> all outputs 0 immediately; after release, first accept dispatches normally.
- addi x5,x0,7 at tail alias 3, then add x6,x5,x5 next cycle -> second packet Qi=Qj=3, Vi=Vj=0; rename x5->3 then x6->4.
- Q1_from_rf=2 with valid_from_alu=1, alias 2, result 0xDEAD same cycle -> Qi=0, Vi=0xDEAD; ALU+LSB both alias 2 -> LSB value wins.
- Q1=5, ready1_from_rob=1, value 0x10 -> Qi=0, Vi=0x10; ready=0 -> Qi=5.
- Two consecutive RS-bound instructions, rs_full=0 -> second stalls one cycle; rs_full=1 or rob_full=1 -> stall_to_dec=1, no pulses.
- rollback concurrent with accept -> no pulses next cycle; rdy=0 for 3 cycles with valid_to_lsb=1 -> pulse held, drops one cycle after rdy=1.
